// File: rtl/pm_pkg.sv
// Shared definitions for the path-metric minimum scanner.
// Optional feature macro: PM_MIN_NORM_EN (in-place renormalisation pass).
package pm_pkg;

  // Default path-metric width and trellis size
  localparam int PM_W          = 6;
  localparam int PM_NUM_STATES = 4;

  // Largest positive value of a signed w-bit metric
  function automatic int pm_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  localparam int PM_MAX = pm_max(PM_W);

  // Legacy-compatible state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FIRST = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FIRST = ST_FIRST,
    S_SCAN  = ST_SCAN,
`ifdef PM_MIN_NORM_EN
    S_NORM  = ST_NORM,
`endif
    S_DONE  = ST_DONE
  } pm_state_e;

endpackage

// File: rtl/pm_lt_cmp.sv
// Combinational signed less-than: a < b is the sign of (a - b) corrected by
// the two's complement overflow of the subtraction.
module pm_lt_cmp #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt
);

  logic [W-1:0] w_sum;
  logic         w_ovf;

  // a + ~b + 1, then sign XOR overflow
  always_comb begin
    w_sum = i_a + ~i_b + {{(W-1){1'b0}}, 1'b1};
    // Overflow only when operand signs differ and result sign differs from a
    w_ovf = (i_a[W-1] != i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
    o_lt  = w_sum[W-1] ^ w_ovf;
  end

endmodule

// File: rtl/pm_min_scanner.sv
// Finds the minimum signed path metric and its state index by scanning the
// metric RAM one entry per cycle through a single shared comparator.
// Optional feature macro: PM_MIN_NORM_EN subtracts the found minimum from
// every RAM entry (saturating) before done is raised.
module pm_min_scanner
  import pm_pkg::*;
#(
  parameter int W          = PM_W,
  parameter int NUM_STATES = PM_NUM_STATES,
  parameter int AW         = $clog2(NUM_STATES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [W-1:0]  i_rd_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [W-1:0]  o_wr_data,
  output logic [W-1:0]  o_min_metric,
  output logic [AW-1:0] o_min_index
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_STATES - 1);
  localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

  pm_state_e     r_state, w_state_next;
  logic [W-1:0]  r_min, w_min_next;
  logic [AW-1:0] r_idx, w_idx_next;
  logic [AW-1:0] r_cnt, w_cnt_next;
  logic          w_lt;

`ifdef PM_MIN_NORM_EN
  localparam logic [AW:0]       NORM_LAST = (AW + 1)'(NUM_STATES);
  localparam logic signed [W:0] SAT_MAX   = (W + 1)'(pm_max(W));

  logic [AW:0]        r_ncnt, w_ncnt_next;
  logic [AW:0]        w_prev;
  logic signed [W:0]  w_diff;
`endif

  pm_lt_cmp #(
    .W (W)
  ) u_lt_cmp (
    .i_a  (i_rd_data),
    .i_b  (r_min),
    .o_lt (w_lt)
  );

  // Next-state, running minimum and read-port control
  always_comb begin
    w_state_next = r_state;
    w_min_next   = r_min;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    o_rd_en      = 1'b0;
    o_rd_addr    = '0;
`ifdef PM_MIN_NORM_EN
    w_ncnt_next  = r_ncnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          o_rd_en      = 1'b1;
          o_rd_addr    = '0;
          w_state_next = S_FIRST;
        end
      end
      S_FIRST: begin
        // Entry 0 seeds the minimum unconditionally
        w_min_next   = i_rd_data;
        w_idx_next   = '0;
        o_rd_en      = 1'b1;
        o_rd_addr    = ONE_ADDR;
        w_cnt_next   = ONE_ADDR;
        w_state_next = S_SCAN;
      end
      S_SCAN: begin
        // Strict less-than keeps the lower index on ties
        if (w_lt) begin
          w_min_next = i_rd_data;
          w_idx_next = r_cnt;
        end
        if (r_cnt != LAST_ADDR) begin
          o_rd_en    = 1'b1;
          o_rd_addr  = r_cnt + ONE_ADDR;
          w_cnt_next = r_cnt + ONE_ADDR;
        end else begin
          w_cnt_next   = '0;
`ifdef PM_MIN_NORM_EN
          w_ncnt_next  = '0;
          w_state_next = S_NORM;
`else
          w_state_next = S_DONE;
`endif
        end
      end
`ifdef PM_MIN_NORM_EN
      S_NORM: begin
        // Read j while writing j-1: one extra cycle drains the last write
        if (r_ncnt != NORM_LAST) begin
          o_rd_en     = 1'b1;
          o_rd_addr   = r_ncnt[AW-1:0];
          w_ncnt_next = r_ncnt + {{AW{1'b0}}, 1'b1};
        end else begin
          w_ncnt_next  = '0;
          w_state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial minimum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_min   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
`ifdef PM_MIN_NORM_EN
      r_ncnt  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_min   <= w_min_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
`ifdef PM_MIN_NORM_EN
      r_ncnt  <= w_ncnt_next;
`endif
    end
  end

`ifdef PM_MIN_NORM_EN
  // Write side of the renormalisation pass: rd_data - min, clamped high
  always_comb begin
    w_prev    = r_ncnt - {{AW{1'b0}}, 1'b1};
    w_diff    = $signed({i_rd_data[W-1], i_rd_data}) - $signed({r_min[W-1], r_min});
    o_wr_en   = (r_state == S_NORM) && (r_ncnt != '0);
    o_wr_addr = '0;
    o_wr_data = '0;
    if (o_wr_en) begin
      o_wr_addr = w_prev[AW-1:0];
      o_wr_data = (w_diff > SAT_MAX) ? SAT_MAX[W-1:0] : w_diff[W-1:0];
    end
  end
`else
  // No renormalisation: write port is inert
  always_comb begin
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_wr_data = '0;
  end
`endif

  // Status and result outputs
  always_comb begin
`ifdef PM_MIN_NORM_EN
    o_busy = (r_state == S_FIRST) || (r_state == S_SCAN) || (r_state == S_NORM);
`else
    o_busy = (r_state == S_FIRST) || (r_state == S_SCAN);
`endif
    o_done       = (r_state == S_DONE);
    o_min_metric = r_min;
    o_min_index  = r_idx;
  end

endmodule

// File: tb/tb_pm_min_scanner.sv
// Directed bench for pm_min_scanner with a 1R1W RAM model (1-cycle read).
// Build with PM_MIN_NORM_EN to also check the renormalised RAM contents.
module tb_pm_min_scanner;

  localparam int W  = 6;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int WIN = 16;
`ifdef PM_MIN_NORM_EN
  localparam int LAT = 2 * N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr, min_index;
  logic [W-1:0]  rd_data, wr_data, min_metric;

  logic [W-1:0]  mem      [N];
  logic [W-1:0]  load_vals[N];
  logic          load;

  int total = 0;
  int bad   = 0;

  pm_min_scanner #(
    .W          (W),
    .NUM_STATES (N),
    .AW         (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_min_metric (min_metric),
    .o_min_index  (min_index)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, data one cycle after rd_en
  always @(posedge clk) begin
    if (load) mem <= load_vals;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input int a, input int b, input int c, input int d);
    @(negedge clk);
    load_vals[0] = W'(a);
    load_vals[1] = W'(b);
    load_vals[2] = W'(c);
    load_vals[3] = W'(d);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Start at window cycle 0, optionally re-pulse start at x1/x2, count dones
  task automatic run_scan(input string tag, input int x1, input int x2,
                          input int exp_min, input int exp_idx);
    int   lat, ndone;
    logic b1, bdone;
    lat = -1; ndone = 0; b1 = 1'b0; bdone = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      start = (k == 0) || (k == x1) || (k == x2);
      if (k == 1) b1 = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat   = k;
          bdone = busy;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_lat"},      lat,   LAT);
    chk({tag, "_ndone"},    ndone, 1);
    chk({tag, "_busy1"},    {31'd0, b1}, 1);
    chk({tag, "_busydone"}, {31'd0, bdone}, 0);
    chk({tag, "_min"},      $signed(min_metric), exp_min);
    chk({tag, "_idx"},      {30'd0, min_index}, exp_idx);
  endtask

`ifdef PM_MIN_NORM_EN
  task automatic chk_mem(input string tag, input int a, input int b, input int c,
                         input int d);
    chk({tag, "_m0"}, $signed(mem[0]), a);
    chk({tag, "_m1"}, $signed(mem[1]), b);
    chk({tag, "_m2"}, $signed(mem[2]), c);
    chk({tag, "_m3"}, $signed(mem[3]), d);
  endtask
`endif

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},  0);
    chk({tag, "_done"},  {31'd0, done},  0);
    chk({tag, "_rden"},  {31'd0, rd_en}, 0);
    chk({tag, "_rdaddr"}, {30'd0, rd_addr}, 0);
    chk({tag, "_wren"},  {31'd0, wr_en}, 0);
    chk({tag, "_wraddr"}, {30'd0, wr_addr}, 0);
    chk({tag, "_wrdata"}, {26'd0, wr_data}, 0);
    chk({tag, "_min"},   {26'd0, min_metric}, 0);
    chk({tag, "_idx"},   {30'd0, min_index}, 0);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Tie between index 1 and 3 keeps index 1
    load_mem(10, -3, 7, -3);
    run_scan("tie", -1, -1, -3, 1);
`ifdef PM_MIN_NORM_EN
    chk_mem("tie", 13, 0, 10, 0);
`endif

    // -32 vs 31 needs the overflow term
    load_mem(31, -32, 0, 5);
    run_scan("ovf", -1, -1, -32, 1);
`ifdef PM_MIN_NORM_EN
    chk_mem("ovf", 31, 0, 31, 31);
`endif

    load_mem(10, 4, 7, 20);
    run_scan("pos", -1, -1, 4, 1);
`ifdef PM_MIN_NORM_EN
    chk_mem("pos", 6, 0, 3, 16);
`endif

    // All equal: index 0 wins
    load_mem(-5, -5, -5, -5);
    run_scan("eq", -1, -1, -5, 0);

    // Minimum in the last entry
    load_mem(3, 2, 1, -8);
    run_scan("last", -1, -1, -8, 3);
`ifdef PM_MIN_NORM_EN
    chk_mem("last", 11, 10, 9, 0);
`endif

    // Extra start pulses while busy / in DONE are ignored
    load_mem(5, 6, -1, 2);
    run_scan("restart", 2, 5, -1, 2);

    // Results hold while idle
    repeat (3) @(negedge clk);
    chk("hold_min", $signed(min_metric), -1);
    chk("hold_idx", {30'd0, min_index}, 2);

    // Asynchronous reset mid-scan
    load_mem(4, -6, 9, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);
    run_scan("fresh", -1, -1, -6, 1);
`ifdef PM_MIN_NORM_EN
    chk_mem("fresh", 10, 0, 15, 7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
